// File: rtl/tmr_scrub_pkg.sv
// Shared types for the TMR arbiter scrubber: FSM states, replica indices and
// the mismatch classification produced by the compare stage.
package tmr_scrub_pkg;

  localparam int REPLICAS = 3;

  typedef logic [1:0] replica_idx_t;

  typedef enum logic [2:0] {
    MONITOR,
    CONFIRM,
    WAIT_IDLE,
    RESYNC,
    SETTLE
  } scrub_state_t;

  typedef enum logic [1:0] {
    AGREE,
    SINGLE,
    TRIPLE
  } mismatch_class_t;

  // One-hot reset mask for a single replica; an out-of-range index selects none.
  function automatic logic [REPLICAS-1:0] replica_mask(input replica_idx_t idx);
    logic [REPLICAS-1:0] mask;
    mask = '0;
    for (int i = 0; i < REPLICAS; i++) begin
      if (idx == replica_idx_t'(i)) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/tmr_mismatch_classify.sv
// Combinational voter: reports whether three replica words agree, whether one
// replica is the odd one out (and which), or whether all three differ.
module tmr_mismatch_classify
  import tmr_scrub_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [W-1:0]    word0,
  input  logic [W-1:0]    word1,
  input  logic [W-1:0]    word2,
  output mismatch_class_t cls,
  output replica_idx_t    k
);

  logic eq01;
  logic eq02;
  logic eq12;

  assign eq01 = (word0 == word1);
  assign eq02 = (word0 == word2);
  assign eq12 = (word1 == word2);

  // The odd replica is the one excluded from the single equal pair.
  always_comb begin
    cls = AGREE;
    k   = '0;
    if (eq01 && eq02) begin
      cls = AGREE;
    end else if (eq12) begin
      cls = SINGLE;
      k   = 2'd0;
    end else if (eq02) begin
      cls = SINGLE;
      k   = 2'd1;
    end else if (eq01) begin
      cls = SINGLE;
      k   = 2'd2;
    end else begin
      cls = TRIPLE;
    end
  end

endmodule

// File: rtl/tmr_arb_scrubber.sv
// Supervisor for a triplicated arbiter: confirms persistent replica faults and
// resyncs the faulty replica once the bus is idle. Optional irq: TMR_SCRUB_IRQ_EN.
module tmr_arb_scrubber
  import tmr_scrub_pkg::*;
#(
  parameter int PORTS          = 4,
  parameter int CONFIRM_CYCLES = 2,
  parameter int RESYNC_CYCLES  = 4,
  parameter int CNT_W          = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PORTS-1:0]    grant_tmr0,
  input  logic [PORTS-1:0]    grant_tmr1,
  input  logic [PORTS-1:0]    grant_tmr2,
  input  logic [REPLICAS-1:0] grant_valid_tmr,
  input  logic                bus_idle,
`ifdef TMR_SCRUB_IRQ_EN
  input  logic                irq_clr,
  output logic                irq,
`endif
  output logic [REPLICAS-1:0] replica_rst,
  output replica_idx_t        fault_idx,
  output logic                fatal,
  output logic [CNT_W-1:0]    fault_count,
  output logic                busy
);

  localparam int W    = PORTS + 1;
  localparam int MAXC = (CONFIRM_CYCLES > RESYNC_CYCLES) ? CONFIRM_CYCLES : RESYNC_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);

  localparam logic [TW-1:0] CONFIRM_LAST = TW'(CONFIRM_CYCLES - 1);
  localparam logic [TW-1:0] RESYNC_LAST  = TW'(RESYNC_CYCLES - 1);

  logic [W-1:0]    word0;
  logic [W-1:0]    word1;
  logic [W-1:0]    word2;
  mismatch_class_t cls;
  replica_idx_t    odd_idx;

  scrub_state_t    state;
  logic [TW-1:0]   cnt;
  replica_idx_t    cand;
  logic            cand_all;

  logic            comparing;
  logic            triple_hit;
  logic            confirm_hit;
  logic [CNT_W-1:0] count_next;

  assign word0 = {grant_valid_tmr[0], grant_tmr0};
  assign word1 = {grant_valid_tmr[1], grant_tmr1};
  assign word2 = {grant_valid_tmr[2], grant_tmr2};

  tmr_mismatch_classify #(
    .W (W)
  ) u_classify (
    .word0 (word0),
    .word1 (word1),
    .word2 (word2),
    .cls   (cls),
    .k     (odd_idx)
  );

  // A fault is confirmed once the same replica has been odd for CONFIRM_CYCLES
  // consecutive samples; with a one-cycle window that happens straight from MONITOR.
  assign comparing   = (state == MONITOR) || (state == CONFIRM);
  assign triple_hit  = comparing && (cls == TRIPLE);
  assign confirm_hit = (cls == SINGLE) &&
                       (((state == MONITOR) && (CONFIRM_CYCLES == 1)) ||
                        ((state == CONFIRM) && (odd_idx == cand) && (cnt == CONFIRM_LAST)));
  assign count_next  = (fault_count == {CNT_W{1'b1}}) ? fault_count
                                                      : fault_count + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= MONITOR;
      cnt         <= '0;
      cand        <= '0;
      cand_all    <= 1'b0;
      replica_rst <= '0;
      fault_idx   <= '0;
      fatal       <= 1'b0;
      fault_count <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        MONITOR, CONFIRM: begin
          if (triple_hit) begin
            fatal    <= 1'b1;
            cand_all <= 1'b1;
            state    <= WAIT_IDLE;
            busy     <= 1'b1;
          end else if (confirm_hit) begin
            cand        <= odd_idx;
            cand_all    <= 1'b0;
            fault_idx   <= odd_idx;
            fault_count <= count_next;
            state       <= WAIT_IDLE;
            busy        <= 1'b1;
          end else if ((cls == SINGLE) && (state == MONITOR)) begin
            cand     <= odd_idx;
            cand_all <= 1'b0;
            cnt      <= TW'(1);
            state    <= CONFIRM;
            busy     <= 1'b1;
          end else if ((cls == SINGLE) && (odd_idx == cand)) begin
            cnt <= cnt + TW'(1);
          end else begin
            state <= MONITOR;
            busy  <= 1'b0;
          end
        end
        WAIT_IDLE: begin
          if (bus_idle) begin
            cnt         <= '0;
            replica_rst <= cand_all ? {REPLICAS{1'b1}} : replica_mask(cand);
            state       <= RESYNC;
          end
        end
        RESYNC: begin
          if (cnt == RESYNC_LAST) begin
            replica_rst <= '0;
            state       <= SETTLE;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end
        SETTLE: begin
          state <= MONITOR;
          busy  <= 1'b0;
        end
        default: begin
          replica_rst <= '0;
          state       <= MONITOR;
          busy        <= 1'b0;
        end
      endcase
    end
  end

`ifdef TMR_SCRUB_IRQ_EN
  // A new fault in the same cycle as a clear must not be lost, so set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else if (triple_hit || confirm_hit) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_tmr_arb_scrubber.sv
// Randomized scoreboard bench for tmr_arb_scrubber: each fault episode pushes
// the expected resync pulse, a negedge monitor pops and checks it.
module tb_tmr_arb_scrubber;

  localparam int P   = 4;
  localparam int C   = 2;
  localparam int R   = 4;
  localparam int CW  = 2;
  localparam int MAXCNT = (1 << CW) - 1;

  localparam int K_SINGLE = 0;
  localparam int K_TRANS  = 1;
  localparam int K_TRIPLE = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [P-1:0]  grant_tmr0;
  logic [P-1:0]  grant_tmr1;
  logic [P-1:0]  grant_tmr2;
  logic [2:0]    grant_valid_tmr;
  logic          bus_idle;
  logic          irq_clr;
  logic [2:0]    replica_rst;
  logic [1:0]    fault_idx;
  logic          fatal;
  logic [CW-1:0] fault_count;
  logic          busy;
`ifdef TMR_SCRUB_IRQ_EN
  logic          irq;
`endif

  tmr_arb_scrubber #(
    .PORTS          (P),
    .CONFIRM_CYCLES (C),
    .RESYNC_CYCLES  (R),
    .CNT_W          (CW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .grant_tmr0      (grant_tmr0),
    .grant_tmr1      (grant_tmr1),
    .grant_tmr2      (grant_tmr2),
    .grant_valid_tmr (grant_valid_tmr),
    .bus_idle        (bus_idle),
`ifdef TMR_SCRUB_IRQ_EN
    .irq_clr         (irq_clr),
    .irq             (irq),
`endif
    .replica_rst     (replica_rst),
    .fault_idx       (fault_idx),
    .fatal           (fatal),
    .fault_count     (fault_count),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] mask;
    int         start;
    int         idx;
    int         count;
    logic       fat;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  int   m_count = 0;
  int   m_idx   = 0;
  logic m_fatal = 1'b0;
  logic m_irq   = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic drive(input logic [P:0] w0, input logic [P:0] w1, input logic [P:0] w2);
    grant_tmr0      = w0[P-1:0];
    grant_tmr1      = w1[P-1:0];
    grant_tmr2      = w2[P-1:0];
    grant_valid_tmr = {w2[P], w1[P], w0[P]};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdleState();
    checkOutput("busy_after", 32'(busy), 32'd0);
    checkOutput("rst_after", 32'(replica_rst), 32'd0);
    checkOutput("count", 32'(fault_count), 32'(m_count));
    checkOutput("fault_idx", 32'(fault_idx), 32'(m_idx));
    checkOutput("fatal", 32'(fatal), 32'(m_fatal));
`ifdef TMR_SCRUB_IRQ_EN
    checkOutput("irq", 32'(irq), 32'(m_irq));
`endif
  endtask

  // Monitor: every rising replica_rst must match the oldest queued expectation.
  logic [2:0] prev_rst = '0;
  logic [2:0] cur_mask = '0;
  int         plen     = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_rst = '0;
      plen     = 0;
    end else begin
      if (replica_rst != 3'b000 && prev_rst == 3'b000) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_pulse", 32'(replica_rst), 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("pulse_mask", 32'(replica_rst), 32'(e.mask));
          checkOutput("pulse_start", 32'(cyc), 32'(e.start));
          checkOutput("pulse_idx", 32'(fault_idx), 32'(e.idx));
          checkOutput("pulse_count", 32'(fault_count), 32'(e.count));
          checkOutput("pulse_fatal", 32'(fatal), 32'(e.fat));
          checkOutput("pulse_busy", 32'(busy), 32'd1);
        end
        cur_mask = replica_rst;
        plen     = 1;
      end else if (replica_rst != 3'b000) begin
        checkOutput("pulse_stable", 32'(replica_rst), 32'(cur_mask));
        plen++;
      end else if (prev_rst != 3'b000) begin
        checkOutput("pulse_len", 32'(plen), 32'(R));
      end
      prev_rst = replica_rst;
    end
  end

  task automatic applyStimulus(input int kind, input int d_req);
    logic [P:0] base, odd, t0, t1, t2;
    int k, b, d, j, hold, n0, len;
    exp_t e;
    base = (P+1)'($urandom);
    k    = $urandom_range(0, 2);
    d    = (d_req < 0) ? $urandom_range(0, 10) : d_req;
    irq_clr = 1'b0;
    n0 = cyc;
    if (kind == K_SINGLE) begin
      odd  = base ^ (P+1)'($urandom_range(1, (1 << (P+1)) - 1));
      j    = (d > C) ? d : C;
      hold = $urandom_range(C, j + R + 1);
      m_count = (m_count == MAXCNT) ? m_count : m_count + 1;
      m_idx   = k;
      m_irq   = 1'b1;
      e.mask = 3'b001 << k; e.start = n0 + 1 + j; e.idx = m_idx;
      e.count = m_count; e.fat = m_fatal;
      exp_q.push_back(e);
      for (int i = 0; i <= j + R + 3; i++) begin
        if (i < hold) drive((k == 0) ? odd : base, (k == 1) ? odd : base, (k == 2) ? odd : base);
        else drive(base, base, base);
        if (i < d) bus_idle = 1'b0;
        else if (i <= j) bus_idle = 1'b1;
        else bus_idle = 1'($urandom);
        irq_clr = (i == C - 1) ? 1'($urandom) : 1'b0;
        step();
      end
    end else if (kind == K_TRIPLE) begin
      t0 = (P+1)'($urandom);
      do t1 = (P+1)'($urandom); while (t1 == t0);
      do t2 = (P+1)'($urandom); while (t2 == t0 || t2 == t1);
      j    = (d > 1) ? d : 1;
      hold = $urandom_range(1, j + R + 1);
      m_fatal = 1'b1;
      m_irq   = 1'b1;
      e.mask = 3'b111; e.start = n0 + 1 + j; e.idx = m_idx;
      e.count = m_count; e.fat = 1'b1;
      exp_q.push_back(e);
      for (int i = 0; i <= j + R + 3; i++) begin
        if (i < hold) drive(t0, t1, t2);
        else drive(t0, t0, t0);
        if (i < d) bus_idle = 1'b0;
        else if (i <= j) bus_idle = 1'b1;
        else bus_idle = 1'($urandom);
        irq_clr = (i == 0) ? 1'($urandom) : 1'b0;
        step();
      end
    end else begin
      // Odd replica for fewer than C cycles, optionally followed by one cycle
      // where a different replica is odd; neither may produce a resync.
      len  = (C > 1) ? $urandom_range(1, C - 1) : 0;
      b    = (k + $urandom_range(1, 2)) % 3;
      odd  = base ^ (P+1)'($urandom_range(1, (1 << (P+1)) - 1));
      hold = $urandom_range(0, 1);
      for (int i = 0; i < len + C + 3; i++) begin
        if (i < len) drive((k == 0) ? odd : base, (k == 1) ? odd : base, (k == 2) ? odd : base);
        else if (i == len && hold == 1 && C > 1)
          drive((b == 0) ? odd : base, (b == 1) ? odd : base, (b == 2) ? odd : base);
        else drive(base, base, base);
        bus_idle = 1'($urandom);
        step();
      end
    end
    irq_clr = 1'b0;
    checkIdleState();
`ifdef TMR_SCRUB_IRQ_EN
    if ($urandom_range(0, 1) == 1) begin
      irq_clr = 1'b1;
      step();
      irq_clr = 1'b0;
      step();
      m_irq = 1'b0;
      checkOutput("irq_cleared", 32'(irq), 32'd0);
    end
`endif
  endtask

  task automatic resetDuringResync();
    logic [P:0] base, odd;
    int k, n0;
    exp_t e;
    base = (P+1)'($urandom);
    odd  = ~base;
    k    = $urandom_range(0, 2);
    n0   = cyc;
    m_count = (m_count == MAXCNT) ? m_count : m_count + 1;
    m_idx   = k;
    e.mask = 3'b001 << k; e.start = n0 + 1 + C; e.idx = k;
    e.count = m_count; e.fat = m_fatal;
    exp_q.push_back(e);
    bus_idle = 1'b1;
    for (int i = 0; i <= C + 1; i++) begin
      if (i < C) drive((k == 0) ? odd : base, (k == 1) ? odd : base, (k == 2) ? odd : base);
      else drive(base, base, base);
      step();
    end
    checkOutput("rst_before_abort", 32'(replica_rst), 32'(3'b001 << k));
    #1;
    rst_n = 1'b0;
    #1;
    m_count = 0; m_idx = 0; m_fatal = 1'b0; m_irq = 1'b0;
    checkOutput("abort_rst", 32'(replica_rst), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_count", 32'(fault_count), 32'd0);
    checkOutput("abort_fatal", 32'(fatal), 32'd0);
`ifdef TMR_SCRUB_IRQ_EN
    checkOutput("abort_irq", 32'(irq), 32'd0);
`endif
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) step();
    checkIdleState();
  endtask

  initial begin
    logic [P:0] w;
    rst_n   = 1'b0;
    irq_clr = 1'b0;
    bus_idle = 1'b1;
    w = 5'b1_0010;
    drive(w, w, w);
    repeat (3) @(posedge clk);
    #1;
    checkIdleState();
    rst_n = 1'b1;
    repeat (2) step();

    applyStimulus(K_SINGLE, 0);
    applyStimulus(K_TRANS, -1);
    applyStimulus(K_SINGLE, 10);
    applyStimulus(K_TRIPLE, 0);
    for (int n = 0; n < 40; n++) begin
      applyStimulus($urandom_range(0, 2), -1);
    end
    resetDuringResync();
    for (int n = 0; n < 5; n++) begin
      applyStimulus(K_SINGLE, -1);
    end
    repeat (5) step();
    checkOutput("pending_pulses", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
